// File: rtl/proc_pkg.sv
// Shared constants, FSM encoding and bus-slicing helper for the 128-entry register bank.
package proc_pkg;

  localparam int DEPTH  = 128;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bit offset of entry idx within the flattened words_out bus.
  function automatic int slice_lo(input int idx);
    return idx * WIDTH;
  endfunction

endpackage

// File: rtl/reg32_en.sv
// One storage entry: load-enabled register with synchronous zero-load and async active-low clear.
module reg32_en
  import proc_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_zero,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Zero-load wins so the clear sweep can never be undone by a same-cycle load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_zero) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank_128.sv
// 128 x 32 register bank with one write port, a one-entry-per-cycle clear sweep,
// and every entry exposed in parallel on a flattened bus for the downstream mux.
module reg_bank_128
  import proc_pkg::*;
#(
  parameter int ZERO_ENTRY0 = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [DEPTH*WIDTH-1:0]   words_out
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_busy;

  assign w_busy   = (r_state == ST_CLEAR);
  assign clr_busy = w_busy;
  assign clr_done = (r_state == ST_DONE);
  assign wr_ready = !w_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi == 0 && ZERO_ENTRY0 != 0) begin : g_zero
      assign words_out[slice_lo(gi) +: WIDTH] = '0;
    end else begin : g_reg
      logic w_load;
      logic w_zero;

      // Writes are gated off during the sweep, so load and zero never collide.
      assign w_load = wr_en && !w_busy && (wr_addr == ADDR_W'(gi));
      assign w_zero = w_busy && (r_cnt == ADDR_W'(gi));

      reg32_en u_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_zero  (w_zero),
        .i_d     (wr_data),
        .o_q     (words_out[slice_lo(gi) +: WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_reg_bank_128.sv
// Directed bench for reg_bank_128: stimulus queues expected observations, a monitor compares them.
module tb_reg_bank_128;

  localparam int K_WORD  = 0;
  localparam int K_READY = 1;
  localparam int K_BUSY  = 2;
  localparam int K_DONE  = 3;
  localparam int K_ZERO  = 4;

  logic          clock;
  logic          reset_n;
  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;
  logic [4095:0] words_out;

  reg_bank_128 #(.ZERO_ENTRY0(1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .words_out (words_out)
  );

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
    int          due;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stop = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d required=0", q.size());
    $fatal(1);
  end

  function automatic void push(input string n, input int k, input int idx,
                               input logic [31:0] e, input int due);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.idx  = idx;
    c.exp  = e;
    c.due  = due;
    q.push_back(c);
  endfunction

  task automatic drive(input bit we, input int a, input logic [31:0] d, input bit cr);
    wr_en   = we;
    wr_addr = 7'(a);
    wr_data = d;
    clr_req = cr;
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    chk_t        it;
    logic [31:0] act;
    while (!stop) begin
      @(posedge clock or negedge reset_n);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        it = q.pop_front();
        case (it.kind)
          K_WORD:  act = words_out[it.idx*32 +: 32];
          K_READY: act = {31'b0, wr_ready};
          K_BUSY:  act = {31'b0, clr_busy};
          K_DONE:  act = {31'b0, clr_done};
          default: act = {31'b0, |words_out};
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s idx=%0d cyc=%0d: got 0x%08h expected 0x%08h",
                   it.name, it.idx, cyc, act, it.exp);
        end
      end
    end
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL leftover: got %0d unchecked expectations expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int k0;
    int j;
    bit busy_e;
    reset_n = 1'b0;
    drive(0, 0, 32'h0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    push("idle_ready", K_READY, 0, 32'd1, cyc + 1);
    push("idle_busy",  K_BUSY,  0, 32'd0, cyc + 1);
    push("idle_done",  K_DONE,  0, 32'd0, cyc + 1);
    push("idle_zero",  K_ZERO,  0, 32'd0, cyc + 1);
    @(negedge clock);

    // Asynchronous reset in mid-cycle wipes a written entry immediately.
    drive(1, 3, 32'h0000_0033, 0);
    push("pre_rst_w3", K_WORD, 3, 32'h0000_0033, cyc + 1);
    @(negedge clock);
    drive(0, 0, 32'h0, 0);
    push("rst_zero",  K_ZERO,  0, 32'd0, cyc);
    push("rst_ready", K_READY, 0, 32'd1, cyc);
    push("rst_busy",  K_BUSY,  0, 32'd0, cyc);
    push("rst_done",  K_DONE,  0, 32'd0, cyc);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Write / readback.
    drive(1, 5, 32'hDEAD_BEEF, 0);
    push("wr5", K_WORD, 5, 32'hDEAD_BEEF, cyc + 1);
    @(negedge clock);
    drive(1, 127, 32'h1234_5678, 0);
    push("wr127", K_WORD, 127, 32'h1234_5678, cyc + 1);
    @(negedge clock);
    drive(0, 0, 32'h0, 0);
    for (int i = 0; i < 128; i++) begin
      push("wr_map", K_WORD, i,
           (i == 5) ? 32'hDEAD_BEEF : (i == 127) ? 32'h1234_5678 : 32'h0, cyc + 1);
    end
    @(negedge clock);

    // Entry 0 ignores writes.
    drive(1, 0, 32'hFFFF_FFFF, 0);
    push("e0_prot", K_WORD, 0, 32'h0, cyc + 1);
    push("e1_keep", K_WORD, 1, 32'h0, cyc + 1);
    @(negedge clock);

    // Fill every entry with its own index.
    for (int i = 0; i < 128; i++) begin
      drive(1, i, 32'(i), 0);
      @(negedge clock);
    end
    drive(0, 0, 32'h0, 0);
    for (int i = 0; i < 128; i++) begin
      push("fill", K_WORD, i, (i == 0) ? 32'h0 : 32'(i), cyc + 1);
    end
    @(negedge clock);

    // Bulk clear with collisions: write+req together, write during sweep,
    // re-request during sweep and during DONE.
    k0 = cyc;
    for (int s = 0; s <= 131; s++) begin
      drive((s == 0) || (s == 5), (s == 0) ? 5 : 10,
            (s == 0) ? 32'hCAFE_F00D : 32'hAAAA_AAAA,
            (s == 0) || (s == 20) || (s == 129));
      j = s + 1;
      busy_e = (j >= 1) && (j <= 128);
      push("clr_busy",  K_BUSY,  j, {31'b0, busy_e},     k0 + j);
      push("clr_done",  K_DONE,  j, {31'b0, j == 129},   k0 + j);
      push("clr_ready", K_READY, j, {31'b0, !busy_e},    k0 + j);
      if (j == 1) push("wr_with_req", K_WORD, 5, 32'hCAFE_F00D, k0 + j);
      if (j == 6) push("wr_in_clear_dropped", K_WORD, 10, 32'd10, k0 + j);
      if (j == 64) begin
        push("mid_62", K_WORD, 62,  32'd0,   k0 + j);
        push("mid_63", K_WORD, 63,  32'd63,  k0 + j);
        push("mid_64", K_WORD, 64,  32'd64,  k0 + j);
        push("mid_127", K_WORD, 127, 32'd127, k0 + j);
      end
      if (j == 129) push("clr_all_zero", K_ZERO, 0, 32'd0, k0 + j);
      @(negedge clock);
    end
    drive(0, 0, 32'h0, 0);

    // Reset in the middle of a sweep: no done pulse, FSM back to idle.
    drive(1, 100, 32'h0000_0064, 0);
    @(negedge clock);
    drive(1, 127, 32'h0000_007F, 0);
    @(negedge clock);
    k0 = cyc;
    for (int s = 0; s <= 60; s++) begin
      drive(0, 0, 32'h0, s == 0);
      j = s + 1;
      if (s == 40) begin
        push("mr_zero",  K_ZERO,  0, 32'd0, cyc);
        push("mr_busy",  K_BUSY,  0, 32'd0, cyc);
        push("mr_done",  K_DONE,  0, 32'd0, cyc);
        push("mr_ready", K_READY, 0, 32'd1, cyc);
        reset_n = 1'b0;
      end
      if (s == 41) reset_n = 1'b1;
      push("mr_busy_t", K_BUSY, j, {31'b0, j <= 40}, k0 + j);
      push("mr_done_t", K_DONE, j, 32'd0, k0 + j);
      if (j == 20) push("mr_e100_pending", K_WORD, 100, 32'h0000_0064, k0 + j);
      @(negedge clock);
    end
    push("mr_e100_gone", K_WORD, 100, 32'h0, cyc + 1);
    push("mr_e127_gone", K_WORD, 127, 32'h0, cyc + 1);
    drive(1, 7, 32'h0000_7777, 0);
    push("post_rst_wr7", K_WORD, 7, 32'h0000_7777, cyc + 1);
    @(negedge clock);
    drive(0, 0, 32'h0, 0);
    repeat (3) @(negedge clock);
    stop = 1'b1;
  end

endmodule

// File: doc/reg_bank_128.md
Name: reg_bank_128

Overview:
- Storage array of 128 x 32-bit entries.
- Sits directly upstream of the 128:1 32-bit read-select mux. It drives all 128 words in parallel on one flattened bus, and the mux picks one of them.
- Provides one synchronous write port.
- Provides a sequenced bulk-clear engine that zeroes one entry per cycle, with busy/done handshake signals.

Parameters:
- DEPTH, 128, number of entries (fixed at 128 to match the downstream select width).
- WIDTH, 32, bits per entry.
- ADDR_W, 7, address width; equals log2(DEPTH).
- ZERO_ENTRY0, 1, when 1, entry 0 is hardwired to zero and ignores writes.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, write request; sampled on the rising edge of clock.
- wr_addr, input, 7, entry index for the write.
- wr_data, input, 32, write data.
- wr_ready, output, 1, high when writes are accepted; equals !clr_busy.
- clr_req, input, 1, request for a bulk clear of all entries.
- clr_busy, output, 1, high while the clear engine is walking the entries.
- clr_done, output, 1, one-cycle pulse when the clear completes.
- words_out, output, 4096, all entries; entry i occupies bits [32i+31:32i].

Behaviour:
- Reset (reset_n low, asynchronous):
  - all 128 entries = 0;
  - FSM = IDLE, clear counter = 0;
  - clr_busy = 0, clr_done = 0, so wr_ready = 1.
  - Reset takes effect immediately, including in the middle of a clear. The clear is abandoned and no clr_done pulse is produced.
- Write path:
  - On a rising edge with wr_en=1 and wr_ready=1, entry[wr_addr] <= wr_data.
  - The new value appears on words_out after that edge (1-cycle write-to-visible latency). There is no read-during-write bypass.
  - wr_en=1 while wr_ready=0 is dropped silently; no entry changes.
  - If ZERO_ENTRY0=1, writes to address 0 are ignored and words_out[31:0] is constant 0.
- words_out is driven purely from the entry flops, with no combinational path from the inputs.
- FSM states:
  - IDLE:
    - clr_busy=0.
    - If clr_req=1 -> CLEAR, counter <= 0.
    - A write presented in the same cycle as clr_req is still accepted (wr_ready is 1 in IDLE). The clear will later overwrite it with 0.
  - CLEAR:
    - clr_busy=1.
    - Each cycle, entry[counter] <= 0 and counter increments.
    - When counter = 127, that entry is zeroed and the FSM -> DONE.
    - The walk takes exactly 128 cycles.
    - clr_req is ignored in this state; requests are not queued.
  - DONE:
    - clr_done=1 for exactly this one cycle; clr_busy=0, so writes are accepted again in this cycle.
    - Next state is IDLE. A clr_req seen in DONE is ignored.
- Counter: 7 bits. It never wraps during CLEAR because the exit happens at 127.
- Entries not yet reached by an in-progress clear keep their old values on words_out until they are zeroed.

Decomposition:
- Shared package (proc_pkg), holding:
  - constants DEPTH=128, WIDTH=32, ADDR_W=7;
  - the FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE);
  - a helper for the flattened-bus slice offset.
- One natural sub-module, reg32_en: a 32-bit register with load enable, synchronous zero-load, and asynchronous active-low clear. Instantiate it 127 times, or 128 times when ZERO_ENTRY0=0.
- The address decode and the FSM stay in the top module.

Test Plan:
1. Reset check: assert reset_n=0 mid-cycle -> words_out is all zeros immediately; wr_ready=1, clr_busy=0, clr_done=0.
2. Write/readback: write 0xDEADBEEF to addr 5 and 0x12345678 to addr 127 -> the next cycle shows bits [191:160]=0xDEADBEEF and [4095:4064]=0x12345678; all other entries stay 0.
3. Entry 0 protection: ZERO_ENTRY0=1, write 0xFFFFFFFF to addr 0 -> words_out[31:0] stays 0.
4. Bulk clear:
   - Stimulus: fill all entries with their index, pulse clr_req.
   - Timing: clr_busy is high for exactly 128 cycles, and clr_done pulses on the following cycle.
   - Final state: all entries are 0.
   - Mid-sweep check at cycle 64: entries 64..127 still hold their index values.
5. Collisions:
   - wr_en to addr 10 during CLEAR -> dropped.
   - wr_en with clr_req in the same IDLE cycle -> the write lands, then is cleared.
   - clr_req during CLEAR -> no second sweep.
6. Reset mid-clear: drop reset_n at cycle 40 of CLEAR -> everything is 0, FSM is IDLE, and no clr_done pulse occurs.
